// File: rtl/seq_mul_if.sv
// rtl/seq_mul_if.sv - request/result bundle for the seq_mul iterative multiplier
interface seq_mul_if #(
    parameter int N = 16
);
    logic         start;
    logic         is_signed;
    logic [N-1:0] rs1_reg;
    logic [N-1:0] rs2_reg;
    logic         busy;
    logic         done;
    logic [N-1:0] mul_rd;
    logic [N-1:0] m_co;
    logic         ovf;

    modport master (
        output start, is_signed, rs1_reg, rs2_reg,
        input  busy, done, mul_rd, m_co, ovf
    );

    modport slave (
        input  start, is_signed, rs1_reg, rs2_reg,
        output busy, done, mul_rd, m_co, ovf
    );
endinterface

// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - iterative shift-add multiplier, optional EARLY_TERM_EN early exit
module seq_mul #(
    parameter int N = 16
) (
    input  logic      clk,
    input  logic      rst,
    seq_mul_if.slave  bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_busy;
    logic   w_done;

    logic [N-1:0]   r_mcand;
    logic [N-1:0]   r_mplr;
    logic [N-1:0]   r_acc_hi;
    logic [CW-1:0]  r_cnt;
    logic           r_neg;
    logic           r_signed;
    logic [N-1:0]   r_mul_rd;
    logic [N-1:0]   r_m_co;
    logic           r_ovf;

    logic           w_accept;
    logic           w_sign1;
    logic           w_sign2;
    logic [N-1:0]   w_mag1;
    logic [N-1:0]   w_mag2;
    logic [N:0]     w_sum;
    logic [N-1:0]   w_acc_nx;
    logic [N-1:0]   w_mplr_nx;
    logic           w_last;
    logic [2*N-1:0] w_prod;
    logic [2*N-1:0] w_res;
    logic           w_ovf;

    // A new request is taken whenever no operation is in flight, including the DONE cycle.
    assign w_accept = bus.start && (r_state != S_RUN);

    // Signed operands are reduced to magnitudes; the sign is reapplied to the full product.
    assign w_sign1 = bus.is_signed & bus.rs1_reg[N-1];
    assign w_sign2 = bus.is_signed & bus.rs2_reg[N-1];
    assign w_mag1  = w_sign1 ? -bus.rs1_reg : bus.rs1_reg;
    assign w_mag2  = w_sign2 ? -bus.rs2_reg : bus.rs2_reg;

    // One conditional add per cycle; the carry becomes the top bit after the right shift.
    assign w_sum     = {1'b0, r_acc_hi} + (r_mplr[0] ? {1'b0, r_mcand} : {(N+1){1'b0}});
    assign w_acc_nx  = w_sum[N:1];
    assign w_mplr_nx = {w_sum[0], r_mplr[N-1:1]};

`ifdef EARLY_TERM_EN
    logic [N-1:0]  r_mrem;
    logic [N-1:0]  w_mrem_nx;
    logic [CW-1:0] w_shamt;

    // Unconsumed multiplier bits; once they are all zero the remaining steps would only shift.
    assign w_mrem_nx = r_mrem >> 1;
    assign w_last    = (r_cnt == CW'(N - 1)) || (w_mrem_nx == '0);
    assign w_shamt   = CW'(N - 1) - r_cnt;
    assign w_prod    = {w_acc_nx, w_mplr_nx} >> w_shamt;

    // Track the remaining multiplier bits alongside the main datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mrem <= '0;
        end else if (w_accept) begin
            r_mrem <= w_mag2;
        end else if (r_state == S_RUN) begin
            r_mrem <= w_mrem_nx;
        end
    end
`else
    assign w_last = (r_cnt == CW'(N - 1));
    assign w_prod = {w_acc_nx, w_mplr_nx};
`endif

    assign w_res = r_neg ? -w_prod : w_prod;
    assign w_ovf = r_signed ? (w_res[2*N-1:N] != {N{w_res[N-1]}})
                            : (w_res[2*N-1:N] != '0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_RUN;
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (w_last) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = bus.start ? S_RUN : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Operand latch, shift-add step, and result capture on the step that enters DONE,
    // so mul_rd/m_co/ovf are already valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplr   <= '0;
            r_acc_hi <= '0;
            r_cnt    <= '0;
            r_neg    <= 1'b0;
            r_signed <= 1'b0;
            r_mul_rd <= '0;
            r_m_co   <= '0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_mcand  <= w_mag1;
            r_mplr   <= w_mag2;
            r_acc_hi <= '0;
            r_cnt    <= '0;
            r_neg    <= w_sign1 ^ w_sign2;
            r_signed <= bus.is_signed;
        end else if (r_state == S_RUN) begin
            r_acc_hi <= w_acc_nx;
            r_mplr   <= w_mplr_nx;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) begin
                r_mul_rd <= w_res[N-1:0];
                r_m_co   <= w_res[2*N-1:N];
                r_ovf    <= w_ovf;
            end
        end
    end

    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.mul_rd = r_mul_rd;
    assign bus.m_co   = r_m_co;
    assign bus.ovf    = r_ovf;
endmodule

// File: tb/tb_seq_mul.sv
// tb/tb_seq_mul.sv - self-checking bench for seq_mul with a cycle-level reference model
module tb_seq_mul;
    localparam int N = 16;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cyc;
    bit   cmp_en;

    seq_mul_if #(.N(N)) bus ();

    seq_mul #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int             due;
        logic [2*N-1:0] p;
        logic           ov;
    } op_t;

    op_t            q[$];
    logic [N-1:0]   exp_lo;
    logic [N-1:0]   exp_hi;
    logic           exp_ov;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [2*N-1:0] prod_of(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        logic signed [2*N-1:0] sa;
        logic signed [2*N-1:0] sb;
        if (s) begin
            sa = signed'({{N{a[N-1]}}, a});
            sb = signed'({{N{b[N-1]}}, b});
            return sa * sb;
        end
        return {{N{1'b0}}, a} * {{N{1'b0}}, b};
    endfunction

    function automatic logic ovf_of(input logic [2*N-1:0] p, input logic s);
        logic signed [2*N-1:0] sp;
        sp = signed'(p);
        if (s) return (sp > (2**(N-1) - 1)) || (sp < -(2**(N-1)));
        return p >= (2*N)'(64'd1 << N);
    endfunction

    function automatic int lat_of(input logic [N-1:0] b, input logic s);
`ifdef EARLY_TERM_EN
        logic [N-1:0] m;
        int k;
        m = (s && b[N-1]) ? -b : b;
        k = 1;
        for (int i = 0; i < N; i++) if (m[i]) k = i + 1;
        return k + 1;
`else
        if (s === 1'bx) return 0;
        return N + 1;
`endif
    endfunction

    // Reference model: accepts requests by its own notion of busy and schedules the done cycle.
    always @(posedge clk) begin
        op_t e;
        if (rst) begin
            q.delete();
            exp_lo = '0;
            exp_hi = '0;
            exp_ov = 1'b0;
        end else if (bus.start && !(q.size() > 0 && cyc < q[0].due)) begin
            e.due = cyc + lat_of(bus.rs2_reg, bus.is_signed);
            e.p   = prod_of(bus.rs1_reg, bus.rs2_reg, bus.is_signed);
            e.ov  = ovf_of(e.p, bus.is_signed);
            q.push_back(e);
        end
        cyc++;
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        logic e_done;
        logic e_busy;
        if (cmp_en) begin
            e_done = (q.size() > 0) && (q[0].due == cyc);
            e_busy = (q.size() > 0) && (cyc < q[0].due);
            if (e_done) begin
                exp_lo = q[0].p[N-1:0];
                exp_hi = q[0].p[2*N-1:N];
                exp_ov = q[0].ov;
                void'(q.pop_front());
            end
            chk("cyc_done", 64'(bus.done), 64'(e_done));
            chk("cyc_busy", 64'(bus.busy), 64'(e_busy));
            chk("cyc_mul_rd", 64'(bus.mul_rd), 64'(exp_lo));
            chk("cyc_m_co", 64'(bus.m_co), 64'(exp_hi));
            chk("cyc_ovf", 64'(bus.ovf), 64'(exp_ov));
        end
    end

    task automatic start_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic s);
        bus.start     = 1'b1;
        bus.rs1_reg   = a;
        bus.rs2_reg   = b;
        bus.is_signed = s;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int lat0, input int exp_lat,
                             input logic [N-1:0] lo, input logic [N-1:0] hi, input logic ov);
        int lat;
        lat = lat0;
        while (bus.done !== 1'b1 && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({name, "_mul_rd"}, 64'(bus.mul_rd), 64'(lo));
        chk({name, "_m_co"}, 64'(bus.m_co), 64'(hi));
        chk({name, "_ovf"}, 64'(bus.ovf), 64'(ov));
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        cyc           = 0;
        cmp_en        = 1'b0;
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.rs1_reg   = '0;
        bus.rs2_reg   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_mul_rd", 64'(bus.mul_rd), 64'd0);
        chk("rst_m_co", 64'(bus.m_co), 64'd0);
        chk("rst_ovf", 64'(bus.ovf), 64'd0);
        cmp_en = 1'b1;

        start_op(16'd3, 16'd5, 1'b0);
        wait_done("u3x5", 1, lat_of(16'd5, 1'b0), 16'h000F, 16'h0000, 1'b0);
`ifndef EARLY_TERM_EN
        chk("u3x5_lat17", 64'(lat_of(16'd5, 1'b0)), 64'd17);
`endif
        @(posedge clk); #1;

        start_op(16'hFFFF, 16'hFFFF, 1'b0);
        wait_done("uffff", 1, lat_of(16'hFFFF, 1'b0), 16'h0001, 16'hFFFE, 1'b1);
        @(posedge clk); #1;

        start_op(16'hFFFF, 16'hFFFF, 1'b1);
        wait_done("sm1m1", 1, lat_of(16'hFFFF, 1'b1), 16'h0001, 16'h0000, 1'b0);
        @(posedge clk); #1;

        start_op(16'h8000, 16'h8000, 1'b1);
        wait_done("s8000", 1, lat_of(16'h8000, 1'b1), 16'h0000, 16'h4000, 1'b1);
        @(posedge clk); #1;

        start_op(16'd7, 16'd9, 1'b0);
`ifdef EARLY_TERM_EN
        repeat (2) @(posedge clk);
`else
        repeat (4) @(posedge clk);
`endif
        #1;
        bus.start   = 1'b1;
        bus.rs1_reg = 16'd2;
        bus.rs2_reg = 16'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
`ifdef EARLY_TERM_EN
        wait_done("ign", 4, lat_of(16'd9, 1'b0), 16'h003F, 16'h0000, 1'b0);
`else
        wait_done("ign", 6, lat_of(16'd9, 1'b0), 16'h003F, 16'h0000, 1'b0);
`endif
        start_op(16'hFFFD, 16'd5, 1'b1);
        wait_done("b2b", 1, lat_of(16'd5, 1'b1), 16'hFFF1, 16'hFFFF, 1'b0);
        @(posedge clk); #1;

        start_op(16'd100, 16'd200, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_busy", 64'(bus.busy), 64'd0);
        chk("mid_rst_done", 64'(bus.done), 64'd0);
        chk("mid_rst_mul_rd", 64'(bus.mul_rd), 64'd0);
        chk("mid_rst_m_co", 64'(bus.m_co), 64'd0);
        chk("mid_rst_ovf", 64'(bus.ovf), 64'd0);
        repeat (20) @(posedge clk);
        #1;
        start_op(16'h1234, 16'h0010, 1'b0);
        wait_done("post_rst", 1, lat_of(16'h0010, 1'b0), 16'h2340, 16'h0001, 1'b1);
        @(posedge clk); #1;

        start_op(16'h7FFF, 16'd2, 1'b1);
        wait_done("s7fffx2", 1, lat_of(16'd2, 1'b1), 16'hFFFE, 16'h0000, 1'b1);
        @(posedge clk); #1;

        start_op(16'h0000, 16'h8000, 1'b1);
        wait_done("s0x8000", 1, lat_of(16'h8000, 1'b1), 16'h0000, 16'h0000, 1'b0);
        @(posedge clk); #1;

`ifdef EARLY_TERM_EN
        start_op(16'd7, 16'd2, 1'b0);
        wait_done("et7x2", 1, 3, 16'd14, 16'h0000, 1'b0);
        @(posedge clk); #1;
        start_op(16'd5, 16'd0, 1'b0);
        wait_done("et5x0", 1, 2, 16'd0, 16'h0000, 1'b0);
        @(posedge clk); #1;
`endif

        repeat (5) @(posedge clk);
        #1;
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
